// File: rtl/patp_pkg.sv
// Shared definitions for the PATP core: opcodes, ALU function codes and the
// sequencer state encoding.
package patp_pkg;

    // Instruction opcodes (IR[DATA_W-1:ADDR_W]).
    localparam logic [2:0] OpClear = 3'b000;
    localparam logic [2:0] OpInc   = 3'b001;
    localparam logic [2:0] OpAdd   = 3'b010;
    localparam logic [2:0] OpDec   = 3'b011;
    localparam logic [2:0] OpJmp   = 3'b100;
    localparam logic [2:0] OpBnz   = 3'b101;
    localparam logic [2:0] OpLoad  = 3'b110;
    localparam logic [2:0] OpStore = 3'b111;

    // ALU function codes; equal to the low two opcode bits of the ALU instructions.
    localparam logic [1:0] AluClear = 2'b00;
    localparam logic [1:0] AluInc   = 2'b01;
    localparam logic [1:0] AluAdd   = 2'b10;
    localparam logic [1:0] AluDec   = 2'b11;

    typedef enum logic [2:0] {
        StInit,
        StFetch,
        StDecode,
        StMem,
        StExec,
        StStall
    } state_e;

endpackage

// File: rtl/patp_decode.sv
// Combinational instruction decoder for the PATP sequencer.
// Ports:
//   opcode      in   3  instruction opcode
//   alu_func    out  2  ALU function for EXEC
//   needs_mem   out  1  instruction has an operand memory access
//   mem_we      out  1  operand access is a write (STORE)
//   writes_acc  out  1  instruction updates D0
//   is_branch   out  1  JMP or BNZ; completes in DECODE
module patp_decode
    import patp_pkg::*;
(
    input  logic [2:0] opcode,
    output logic [1:0] alu_func,
    output logic       needs_mem,
    output logic       mem_we,
    output logic       writes_acc,
    output logic       is_branch
);

    always_comb begin
        alu_func   = opcode[1:0];
        needs_mem  = 1'b0;
        mem_we     = 1'b0;
        writes_acc = 1'b0;
        is_branch  = 1'b0;
        case (opcode)
            OpClear, OpInc, OpDec: writes_acc = 1'b1;
            OpAdd, OpLoad: begin
                needs_mem  = 1'b1;
                writes_acc = 1'b1;
            end
            OpStore: begin
                needs_mem = 1'b1;
                mem_we    = 1'b1;
            end
            OpJmp, OpBnz: is_branch = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/patp_control.sv
// Fetch/decode/execute sequencer for the PATP core. Owns PC, IR, MDR, D0 and
// the Z flag, drives the neighbouring ALU and a unified memory over req/ack.
// Optional build macro: PATP_SINGLE_STEP_EN adds a `step` input and a STALL
// state entered after INIT and after every retire.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   step                       (PATP_SINGLE_STEP_EN only) leave STALL
//   mem_req/we/addr/wdata      memory request, held until mem_ack
//   mem_rdata, mem_ack         read data and 1-cycle completion pulse
//   alu_func, alu_p, alu_q     ALU function and operands (MDR, D0)
//   alu_result, alu_zero       ALU outputs captured in EXEC
//   pc, acc, z_flag            architectural state
//   retire                     1-cycle pulse on instruction completion
module patp_control
    import patp_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef PATP_SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        alu_func,
    output logic [DATA_W-1:0] alu_p,
    output logic [DATA_W-1:0] alu_q,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              z_flag,
    output logic              retire
);

`ifdef PATP_SINGLE_STEP_EN
    localparam state_e AfterRetire = StStall;
`else
    localparam state_e AfterRetire = StFetch;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] d0_q, d0_d;
    logic              z_q, z_d;

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [1:0]        dec_func;
    logic              dec_needs_mem;
    logic              dec_we;
    logic              dec_writes_acc;
    logic              dec_branch;

    assign opcode  = ir_q[DATA_W-1:ADDR_W];
    assign operand = ir_q[ADDR_W-1:0];

    patp_decode u_decode (
        .opcode     (opcode),
        .alu_func   (dec_func),
        .needs_mem  (dec_needs_mem),
        .mem_we     (dec_we),
        .writes_acc (dec_writes_acc),
        .is_branch  (dec_branch)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StInit;
            pc_q    <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            d0_q    <= '0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            d0_q    <= d0_d;
            z_q     <= z_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        d0_d      = d0_q;
        z_d       = z_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        alu_func  = AluClear;
        retire    = 1'b0;
        unique case (state_q)
            // One idle cycle keeps mem_req low straight out of reset.
            StInit: state_d = AfterRetire;
`ifdef PATP_SINGLE_STEP_EN
            StStall: if (step) state_d = StFetch;
`endif
            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_branch) begin
                    if (opcode == OpJmp || !z_q) pc_d = operand;
                    retire  = 1'b1;
                    state_d = AfterRetire;
                end else if (dec_needs_mem) begin
                    state_d = StMem;
                end else begin
                    state_d = StExec;
                end
            end
            StMem: begin
                mem_req  = 1'b1;
                mem_we   = dec_we;
                mem_addr = operand;
                if (dec_we) mem_wdata = d0_q;
                if (mem_ack) begin
                    if (!dec_writes_acc) begin
                        retire  = 1'b1;
                        state_d = AfterRetire;
                    end else if (opcode == OpLoad) begin
                        d0_d    = mem_rdata;
                        z_d     = (mem_rdata == '0);
                        retire  = 1'b1;
                        state_d = AfterRetire;
                    end else begin
                        // ADD: operand parked in MDR, summed in EXEC.
                        mdr_d   = mem_rdata;
                        state_d = StExec;
                    end
                end
            end
            StExec: begin
                alu_func = dec_func;
                d0_d     = alu_result;
                z_d      = alu_zero;
                retire   = 1'b1;
                state_d  = AfterRetire;
            end
            default: state_d = StInit;
        endcase
    end

    assign alu_p  = mdr_q;
    assign alu_q  = d0_q;
    assign pc     = pc_q;
    assign acc    = d0_q;
    assign z_flag = z_q;

endmodule

// File: tb/tb_patp_control.sv
// Bench for patp_control: a memory responder with programmable ack delay and
// stray acks, a combinational ALU, and an instruction-level ISA model that is
// stepped on every retire and compared against the DUT every cycle.
module tb_patp_control;

`ifdef PATP_SINGLE_STEP_EN
    localparam int SS = 1;
`else
    localparam int SS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
`ifdef PATP_SINGLE_STEP_EN
    logic       step = 1'b1;
`endif
    logic       mem_req, mem_we, mem_ack;
    logic [4:0] mem_addr, pc;
    logic [7:0] mem_wdata, mem_rdata, alu_p, alu_q, alu_result, acc;
    logic [1:0] alu_func;
    logic       alu_zero, z_flag, retire;

    always #5 clk = ~clk;

    patp_control #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef PATP_SINGLE_STEP_EN
        .step       (step),
`endif
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .alu_func   (alu_func),
        .alu_p      (alu_p),
        .alu_q      (alu_q),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .pc         (pc),
        .acc        (acc),
        .z_flag     (z_flag),
        .retire     (retire)
    );

    // ALU that sits beside the sequencer.
    always_comb begin
        case (alu_func)
            2'b00:   alu_result = 8'd0;
            2'b01:   alu_result = alu_q + 8'd1;
            2'b10:   alu_result = alu_p + alu_q;
            default: alu_result = alu_q - 8'd1;
        endcase
        alu_zero = (alu_result == 8'd0);
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    logic [7:0] prog    [32];
    logic [7:0] mem     [32];
    logic [7:0] ref_mem [32];
    logic [4:0] ref_pc;
    logic [7:0] ref_acc;
    logic       ref_z;
    int min_wait = 0, max_wait = 0;
    bit stray_en = 0;
    int wait_cnt = 0, wait_base = 0;
    int cyc = 0, tcyc = 0, last_ret_tcyc = 0, nret = 0, phase = 0;
    bit pending = 0;

    // Memory responder: decides ack for the current cycle on the falling edge.
    initial begin
        int  wl;
        bit  busy;
        busy      = 0;
        wl        = 0;
        mem_ack   = 1'b0;
        mem_rdata = 8'd0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            if (!rst_n) begin
                mem  = prog;
                busy = 0;
            end else if (mem_req) begin
                if (!busy) begin
                    busy = 1;
                    wl   = int'($urandom_range(max_wait, min_wait));
                end
                if (wl == 0) begin
                    mem_ack = 1'b1;
                    busy    = 0;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    else        mem_rdata = mem[mem_addr];
                end else begin
                    wl--;
                    wait_cnt++;
                end
            end else if (stray_en && $urandom_range(3, 0) == 0) begin
                mem_ack = 1'b1;
            end
        end
    end

    // ISA model and per-cycle compare.
    initial begin
        logic [7:0] ins;
        logic [2:0] op;
        logic [4:0] a, nxt;
        int         lat, nacc;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                ref_mem   = prog;
                ref_pc    = 5'd0;
                ref_acc   = 8'd0;
                ref_z     = 1'b0;
                cyc       = 0;
                tcyc      = 0;
                phase     = 0;
                pending   = 0;
                wait_base = wait_cnt;
            end else begin
                cyc++;
                tcyc++;
                if (pending) begin
                    check("pc", pc, ref_pc);
                    check("acc", acc, ref_acc);
                    check("z_flag", z_flag, ref_z);
                    pending = 0;
                end
                ins = ref_mem[ref_pc];
                op  = ins[7:5];
                a   = ins[4:0];
                if (mem_req) begin
                    check("mem_addr", mem_addr, (phase == 0) ? ref_pc : a);
                    check("mem_we", mem_we, (phase == 1 && op == 3'd7));
                    if (mem_we) check("mem_wdata", mem_wdata, ref_acc);
                    if (mem_ack) phase++;
                end
                if (retire) begin
                    lat  = (op == 3'd4 || op == 3'd5) ? 2 : (op == 3'd2) ? 4 : 3;
                    nacc = (op == 3'd2 || op == 3'd6 || op == 3'd7) ? 2 : 1;
                    check("latency", cyc, lat + (wait_cnt - wait_base) + SS);
                    check("accesses", phase, nacc);
                    nxt = ref_pc + 5'd1;
                    case (op)
                        3'd0: begin ref_acc = 8'd0; ref_z = 1'b1; end
                        3'd1: begin ref_acc = ref_acc + 8'd1; ref_z = (ref_acc == 8'd0); end
                        3'd2: begin ref_acc = ref_acc + ref_mem[a]; ref_z = (ref_acc == 8'd0); end
                        3'd3: begin ref_acc = ref_acc - 8'd1; ref_z = (ref_acc == 8'd0); end
                        3'd4: nxt = a;
                        3'd5: if (!ref_z) nxt = a;
                        3'd6: begin ref_acc = ref_mem[a]; ref_z = (ref_acc == 8'd0); end
                        default: ref_mem[a] = ref_acc;
                    endcase
                    ref_pc        = nxt;
                    pending       = 1;
                    cyc           = 0;
                    phase         = 0;
                    wait_base     = wait_cnt;
                    last_ret_tcyc = tcyc;
                    nret++;
                end
            end
        end
    end

    task automatic start_reset();
        rst_n = 1'b0;
        #1;
        check("rst mem_req", mem_req, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst alu_func", alu_func, 0);
        check("rst alu_p", alu_p, 0);
        check("rst alu_q", alu_q, 0);
        check("rst pc", pc, 0);
        check("rst acc", acc, 0);
        check("rst z_flag", z_flag, 0);
        check("rst retire", retire, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        check("init mem_req", mem_req, 0);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 8'h00;
    endtask

    task automatic run(input int n, input int budget);
        int target;
        int k;
        target = nret + n;
        k      = 0;
        while (nret < target && k < budget) begin
            @(negedge clk);
            #4;
            k++;
        end
        check("run completed", (nret >= target) ? 1 : 0, 1);
        @(negedge clk);
        #4;
    endtask

    initial begin
        int k;
        #1;
        start_reset();

        // 1: INC, INC, DEC, then park on JMP 3.
        clear_prog();
        prog[0] = 8'h20; prog[1] = 8'h20; prog[2] = 8'h60; prog[3] = 8'h83;
        release_reset();
        run(3, 100);
        check("t1 acc", acc, 8'd1);
        check("t1 model acc", ref_acc, 8'd1);
        check("t1 z", z_flag, 0);
        check("t1 pc", pc, 5'd3);
        check("t1 cycles", last_ret_tcyc, 9 + 3 * SS);

        // 2: LOAD 10 (=FF), INC, BNZ 0 not taken.
        @(negedge clk); #4; start_reset();
        clear_prog();
        prog[0] = 8'hCA; prog[1] = 8'h20; prog[2] = 8'hA0; prog[3] = 8'h83; prog[10] = 8'hFF;
        release_reset();
        run(3, 100);
        check("t2 acc", acc, 8'h00);
        check("t2 z", z_flag, 1);
        check("t2 model z", ref_z, 1);
        check("t2 pc", pc, 5'd3);

        // 3: CLEAR; ADD 10 (=5); STORE 11; JMP 7; JMP 7.
        @(negedge clk); #4; start_reset();
        clear_prog();
        prog[0] = 8'h00; prog[1] = 8'h4A; prog[2] = 8'hEB; prog[3] = 8'h87;
        prog[7] = 8'h87; prog[10] = 8'h05;
        release_reset();
        run(4, 100);
        check("t3 mem[11]", mem[11], 8'h05);
        check("t3 acc", acc, 8'h05);
        check("t3 pc", pc, 5'd7);
        check("t3 cycles", last_ret_tcyc, 12 + 4 * SS);

        // 4: every access acked after 3 wait cycles.
        @(negedge clk); #4; start_reset();
        clear_prog();
        prog[0] = 8'h20; prog[1] = 8'h20; prog[2] = 8'h60; prog[3] = 8'h83;
        min_wait = 3; max_wait = 3;
        release_reset();
        run(3, 200);
        check("t4 acc", acc, 8'd1);
        check("t4 cycles", last_ret_tcyc, 18 + 3 * SS);

        // 5: JMP 31; INC at 31 wraps PC to 0.
        @(negedge clk); #4; start_reset();
        min_wait = 0; max_wait = 0;
        clear_prog();
        prog[0] = 8'h9F; prog[31] = 8'h20;
        release_reset();
        run(2, 100);
        check("t5 pc wrap", pc, 5'd0);
        check("t5 acc", acc, 8'd1);

        // 6: reset while LOAD waits in MEM, then refetch from 0.
        @(negedge clk); #4; start_reset();
        clear_prog();
        prog[0] = 8'hCA; prog[1] = 8'h83; prog[3] = 8'h83; prog[10] = 8'hFF;
        min_wait = 3; max_wait = 3;
        release_reset();
        k = 0;
        while (!(mem_req && phase == 1) && k < 50) begin
            @(negedge clk);
            #4;
            k++;
        end
        check("t6 reached MEM", (mem_req && phase == 1) ? 1 : 0, 1);
        start_reset();
        min_wait = 0; max_wait = 0;
        release_reset();
        run(1, 100);
        check("t6 acc", acc, 8'hFF);
        check("t6 z", z_flag, 0);
        check("t6 pc", pc, 5'd1);

        // Random programs, random ack delays, stray acks while idle.
        stray_en = 1;
        min_wait = 0; max_wait = 3;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk); #4; start_reset();
            for (int i = 0; i < 32; i++) prog[i] = 8'($urandom);
            release_reset();
            run(150, 3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
